modbus_frame_rx: RTL and testbench

- Upstream framing stage of the Modbus RTU slave. It takes received bytes from the UART receiver and delimits RTU frames using the 3.5-character silence rule.
- It assembles one fixed-length 8-byte request: address, function, 4 data bytes, CRC low byte, CRC high byte.
- On a valid frame it presents the 6 payload bytes and the received CRC to the CRC checker, with a one-cycle rx_message_done strobe.
- Malformed frames (wrong length) are dropped and flagged.

---
 rtl/modbus_frame_rx.sv | 102 ++++++++++
 tb/tb_modbus_frame_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/modbus_frame_rx.sv
// Modbus RTU framing stage: delimits frames on 3.5-character line silence and
// assembles fixed 8-byte requests into a payload word plus the received CRC.
module modbus_frame_rx #(
  parameter int T35_CYCLES = 3646,
  parameter int FRAME_LEN  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [47:0] data_out,
  output logic [15:0] crc_rx,
  output logic        rx_message_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int             GAP_W   = $clog2(T35_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(T35_CYCLES);
  localparam logic [GAP_W-1:0] GAP_TMO = GAP_W'(T35_CYCLES - 1);
  localparam logic [3:0]     LEN     = 4'(FRAME_LEN);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_RECV, S_OVERRUN, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [3:0]       r_byte_cnt;
  logic [63:0]      r_shift;
  logic             w_tmo;

  // A byte in the same cycle always beats the silence timeout.
  assign w_tmo = !rx_valid && (r_gap_cnt == GAP_TMO);
  assign busy  = (r_state == S_RECV) || (r_state == S_OVERRUN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= S_SYNC;
      r_gap_cnt       <= '0;
      r_byte_cnt      <= '0;
      r_shift         <= '0;
      data_out        <= '0;
      crc_rx          <= '0;
      rx_message_done <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      rx_message_done <= 1'b0;
      frame_err       <= 1'b0;

      if (rx_valid)
        r_gap_cnt <= '0;
      else if (r_gap_cnt != GAP_MAX)
        r_gap_cnt <= r_gap_cnt + 1'b1;

      case (r_state)
        S_SYNC: begin
          if (w_tmo)
            r_state <= S_IDLE;
        end
        // DONE and ERR last one cycle but may already accept the next frame's first byte.
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_valid) begin
            r_shift    <= {r_shift[55:0], rx_byte};
            r_byte_cnt <= 4'd1;
            r_state    <= S_RECV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            if (r_byte_cnt < LEN) begin
              r_shift    <= {r_shift[55:0], rx_byte};
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end else begin
              r_state <= S_OVERRUN;
            end
          end else if (w_tmo) begin
            if (r_byte_cnt == LEN) begin
              data_out        <= r_shift[63:16];
              crc_rx          <= {r_shift[7:0], r_shift[15:8]};
              rx_message_done <= 1'b1;
              r_state         <= S_DONE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_ERR;
            end
          end
        end
        S_OVERRUN: begin
          if (w_tmo) begin
            frame_err <= 1'b1;
            r_state   <= S_ERR;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_rx.sv
// Directed bench for modbus_frame_rx with a 20-cycle silence timeout.
module tb_modbus_frame_rx;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [47:0] data_out;
  logic [15:0] crc_rx;
  logic        rx_message_done;
  logic        frame_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cnt_done = 0;
  int cnt_err  = 0;
  int cnt_bad  = 0;
  logic prev_strobe = 1'b0;

  modbus_frame_rx #(.T35_CYCLES(20), .FRAME_LEN(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .data_out(data_out), .crc_rx(crc_rx), .rx_message_done(rx_message_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rx_message_done) cnt_done++;
    if (frame_err) cnt_err++;
    if ((rx_message_done && frame_err) || ((rx_message_done || frame_err) && prev_strobe))
      cnt_bad++;
    prev_strobe = rx_message_done || frame_err;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Bytes are top-aligned in the 64-bit word; gap idle cycles follow every byte but the last.
  task automatic send_bytes(input logic [63:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[63-8*i -: 8]);
      if (i != n - 1) idle(gap);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    idle(2);
    checks++; if (data_out !== 48'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (crc_rx !== 16'h0) begin failures++; $display("FAIL reset_crc got=%h exp=0", crc_rx); end
    checks++; if (rx_message_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_message_done); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_in = 1'b0;
  endtask

  task automatic test_sync_ignore();
    int d0, e0;
    d0 = cnt_done; e0 = cnt_err;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h55 + 8'(i));
      idle(5);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sync_busy got=%b exp=0", busy); end
    idle(25);
    checks++; if ((cnt_done - d0) !== 0 || (cnt_err - e0) !== 0)
      begin failures++; $display("FAIL sync_strobes done=%0d err=%0d exp 0 0", cnt_done - d0, cnt_err - e0); end
  endtask

  task automatic test_basic();
    int d0;
    d0 = cnt_done;
    send_bytes(64'h010300000001840A, 8, 9);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    idle(19);
    checks++; if (rx_message_done !== 1'b0) begin failures++; $display("FAIL basic_early got=%b exp=0", rx_message_done); end
    tick();
    checks++; if (rx_message_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", rx_message_done); end
    checks++; if (data_out !== 48'h010300000001) begin failures++; $display("FAIL basic_data got=%h exp=010300000001", data_out); end
    checks++; if (crc_rx !== 16'h0A84) begin failures++; $display("FAIL basic_crc got=%h exp=0a84", crc_rx); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", frame_err); end
    tick();
    checks++; if (rx_message_done !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", rx_message_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    idle(30);
    checks++; if ((cnt_done - d0) !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", cnt_done - d0); end
  endtask

  task automatic test_short();
    int d0, e0;
    d0 = cnt_done; e0 = cnt_err;
    send_bytes(64'hAABBCCDDEE000000, 5, 9);
    idle(20);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", frame_err); end
    idle(10);
    checks++; if ((cnt_err - e0) !== 1 || (cnt_done - d0) !== 0)
      begin failures++; $display("FAIL short_counts err=%0d done=%0d exp 1 0", cnt_err - e0, cnt_done - d0); end
    checks++; if (data_out !== 48'h010300000001) begin failures++; $display("FAIL short_hold got=%h exp=010300000001", data_out); end
    checks++; if (crc_rx !== 16'h0A84) begin failures++; $display("FAIL short_crc_hold got=%h exp=0a84", crc_rx); end
  endtask

  task automatic test_overrun();
    int d0, e0;
    d0 = cnt_done; e0 = cnt_err;
    send_bytes(64'h1020304050607080, 8, 2);
    idle(2);
    send_byte(8'h90);
    idle(2);
    send_byte(8'hA0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovr_busy got=%b exp=1", busy); end
    idle(20);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ovr_err got=%b exp=1", frame_err); end
    idle(10);
    checks++; if ((cnt_err - e0) !== 1 || (cnt_done - d0) !== 0)
      begin failures++; $display("FAIL ovr_counts err=%0d done=%0d exp 1 0", cnt_err - e0, cnt_done - d0); end
    checks++; if (data_out !== 48'h010300000001) begin failures++; $display("FAIL ovr_hold got=%h exp=010300000001", data_out); end
  endtask

  task automatic test_gap();
    int d0, e0;
    d0 = cnt_done; e0 = cnt_err;
    send_bytes(64'h1122334455667788, 8, 19);
    idle(20);
    checks++; if (rx_message_done !== 1'b1) begin failures++; $display("FAIL gap19_done got=%b exp=1", rx_message_done); end
    checks++; if (data_out !== 48'h112233445566) begin failures++; $display("FAIL gap19_data got=%h exp=112233445566", data_out); end
    checks++; if (crc_rx !== 16'h8877) begin failures++; $display("FAIL gap19_crc got=%h exp=8877", crc_rx); end
    checks++; if ((cnt_err - e0) !== 0) begin failures++; $display("FAIL gap19_err got=%0d exp=0", cnt_err - e0); end
    idle(10);
    d0 = cnt_done; e0 = cnt_err;
    send_bytes(64'hA1A2A3A400000000, 4, 19);
    idle(20);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL gap20_err got=%b exp=1", frame_err); end
    send_bytes(64'hB5B6B7B800000000, 4, 19);
    idle(30);
    checks++; if ((cnt_err - e0) !== 2 || (cnt_done - d0) !== 0)
      begin failures++; $display("FAIL gap20_counts err=%0d done=%0d exp 2 0", cnt_err - e0, cnt_done - d0); end
    checks++; if (data_out !== 48'h112233445566) begin failures++; $display("FAIL gap20_hold got=%h exp=112233445566", data_out); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = cnt_done; e0 = cnt_err;
    send_bytes(64'hE1E2E3E4E5000000, 5, 9);
    idle(3);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 48'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", data_out); end
    idle(25);
    checks++; if ((cnt_err - e0) !== 0 || (cnt_done - d0) !== 0)
      begin failures++; $display("FAIL rstmid_strobes err=%0d done=%0d exp 0 0", cnt_err - e0, cnt_done - d0); end
    send_bytes(64'hC0C1C2C3C4C5C6C7, 8, 9);
    idle(20);
    checks++; if (rx_message_done !== 1'b1) begin failures++; $display("FAIL rstmid_done got=%b exp=1", rx_message_done); end
    checks++; if (data_out !== 48'hC0C1C2C3C4C5) begin failures++; $display("FAIL rstmid_frame got=%h exp=c0c1c2c3c4c5", data_out); end
    checks++; if (crc_rx !== 16'hC7C6) begin failures++; $display("FAIL rstmid_crc got=%h exp=c7c6", crc_rx); end
  endtask

  task automatic test_back_to_back();
    idle(10);
    send_bytes(64'h0102030405060708, 8, 9);
    idle(20);
    checks++; if (rx_message_done !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", rx_message_done); end
    send_bytes(64'hD0D1D2D3D4D5D6D7, 8, 9);
    checks++; if (data_out !== 48'h010203040506) begin failures++; $display("FAIL b2b_hold got=%h exp=010203040506", data_out); end
    idle(20);
    checks++; if (rx_message_done !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b exp=1", rx_message_done); end
    checks++; if (data_out !== 48'hD0D1D2D3D4D5) begin failures++; $display("FAIL b2b_data got=%h exp=d0d1d2d3d4d5", data_out); end
    checks++; if (crc_rx !== 16'hD7D6) begin failures++; $display("FAIL b2b_crc got=%h exp=d7d6", crc_rx); end
    idle(5);
  endtask

  task automatic test_exclusive();
    checks++; if (cnt_bad !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", cnt_bad); end
  endtask

  initial begin
    test_reset();
    test_sync_ignore();
    test_basic();
    test_short();
    test_overrun();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
